reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- Parametrised multi-word register bank with per-write operation modes.
- Generalises the single 16-bit load register into DEPTH words of WIDTH bits, with one write port and two combinational read ports.
- Adds synchronous reset, in-place increment with overflow flag, clear, optional hardwired-zero word 0, and optional write-to-read bypass.
- Sits between the CPU datapath and ALU as the general-purpose register store.

Parameters:
- WIDTH, 16, bits per word (>=1).
- DEPTH, 8, number of words (>=2; need not be a power of 2).
- BYPASS, 1, 1 = read ports see the same-cycle write result; 0 = read ports see stored value only.
- ZERO_REG, 0, 1 = word 0 always reads 0 and ignores all writes.
- AW (localparam), max(1, $clog2(DEPTH)), address width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_op  in  2  write operation: 00 NONE, 01 LOAD, 10 INC, 11 CLR.
- wr_addr  in  AW  target word of write.
- wr_data  in  WIDTH  data for LOAD; ignored otherwise.
- rd_addr_a  in  AW  read port A address.
- rd_data_a  out  WIDTH  read port A data, combinational.
- rd_addr_b  in  AW  read port B address.
- rd_data_b  out  WIDTH  read port B data, combinational.
- ovf  out  1  registered flag: INC on the previous edge wrapped all-ones to zero.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset: on rising clk with reset=1, all words := 0 and ovf := 0. Reset wins over any wr_op in the same cycle. No state changes without a clk edge.
- LOAD: word[wr_addr] := wr_data at the edge; ovf := 0.
- INC: word[wr_addr] := word[wr_addr]+1 mod 2^WIDTH. ovf := 1 iff the old value was all-ones, else 0.
- CLR: word[wr_addr] := 0; ovf := 0.
- NONE: no word changes; ovf := 0. ovf is therefore a one-cycle pulse per wrapping INC.
- Out-of-range address (wr_addr >= DEPTH): the write is ignored and ovf := 0.
- ZERO_REG=1 with wr_addr = 0: the write is ignored and ovf := 0.
- Reads: rd_data_x = word[rd_addr_x], combinational, zero-latency relative to address.
- Out-of-range read, or ZERO_REG=1 read of address 0, returns 0.
- Bypass (BYPASS=1, rd_addr_x == wr_addr, write effective, reset=0): rd_data_x shows the next value:
  - LOAD: wr_data.
  - INC: old+1 (wrapped).
  - CLR: 0.
  - With reset=1, read returns the stored value (no bypass).
- Bypass off (BYPASS=0): read shows the stored value; the new value is visible the cycle after the edge.
- Both read ports may address the same word, including the word being written; each port obeys the rules above independently.
- Latency: write-to-storage 1 clk; storage-to-read 0; ovf valid 1 clk after the INC edge.
- No X propagation: every word holds a defined value after the first reset.

Decomposition:
- Shared package reg_pkg:
  - typedef enum logic [1:0] wr_op_t {OP_NONE, OP_LOAD, OP_INC, OP_CLR}.
  - Function next_val(wr_op_t op, cur, din) returning {wrap, next}, used by both storage and bypass paths.
- Sub-module reg_word:
  - One WIDTH-bit word with clk, reset, sel, op, din, q, wrap.
  - reg_file instantiates DEPTH of them via generate, decodes wr_addr to sel, and builds the two read muxes plus bypass.
  - Word 0 is tied to constant 0 when ZERO_REG=1.

Test Plan:
- Reset then read: assert reset 1 clk, sweep rd_addr_a/b over 0..7 -> all reads 0, ovf=0. Then LOAD addr 3 = 16'hBEEF concurrently with reset=1 -> word 3 still 0.
- Load/readback: LOAD addr 2 = 16'h1234, then addr 5 = 16'hA5A5 -> next cycle rd_a(2)=16'h1234, rd_b(5)=16'hA5A5; other words 0.
- INC wrap: LOAD addr 1 = 16'hFFFE, INC, INC -> word 1 = 16'hFFFF then 16'h0000. ovf=0 after the first INC, 1 after the second, 0 on the following NONE cycle.
- Bypass: BYPASS=1, word 4 = 16'h0010, INC addr 4 with rd_addr_a=rd_addr_b=4 -> both read 16'h0011 in the same cycle. Same with BYPASS=0 -> 16'h0010 same cycle, 16'h0011 next.
- ZERO_REG=1: LOAD addr 0 = 16'hFFFF, then INC addr 0 -> rd(0)=0 throughout, ovf never 1.
- Range and CLR: DEPTH=6, LOAD addr 7 = 16'h5555 -> no word changes, rd(7)=0. CLR addr 2 after load 16'h1234 -> rd(2)=0 next cycle.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and the next-value rule used by both the word storage and the read bypass.
package reg_pkg;
  typedef enum logic [1:0] {OP_NONE, OP_LOAD, OP_INC, OP_CLR} wr_op_t;

  localparam int MAX_W = 64;

  typedef struct packed {
    logic             wrap;
    logic [MAX_W-1:0] nxt;
  } nv_t;

  // Widths up to MAX_W are handled by masking to the caller's width w.
  function automatic nv_t next_val(wr_op_t op, logic [MAX_W-1:0] cur,
                                   logic [MAX_W-1:0] din, int w);
    logic [MAX_W-1:0] mask;
    nv_t r;
    mask   = {MAX_W{1'b1}} >> (MAX_W - w);
    r.wrap = 1'b0;
    r.nxt  = cur & mask;
    case (op)
      OP_LOAD: r.nxt = din & mask;
      OP_INC: begin
        r.nxt  = (cur + 1'b1) & mask;
        r.wrap = ((cur & mask) == mask);
      end
      OP_CLR:  r.nxt = '0;
      default: ;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/reg_file_word.sv
// One storage word; applies the selected write op on the rising edge.
module reg_word import reg_pkg::*; #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  wr_op_t           op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);
  logic [WIDTH-1:0] q_q, q_d;
  nv_t              nv;
  logic             unused_nv;

  always_comb begin
    nv   = next_val(op, MAX_W'(q_q), MAX_W'(din), WIDTH);
    q_d  = sel ? nv.nxt[WIDTH-1:0] : q_q;
    wrap = sel & nv.wrap;
  end

  assign unused_nv = ^nv;

  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/reg_file.sv
// DEPTH x WIDTH register bank: one write port with LOAD/INC/CLR, two combinational
// read ports with optional same-cycle bypass, and a registered INC-wrap flag.
module reg_file import reg_pkg::*; #(
  parameter  int WIDTH    = 16,
  parameter  int DEPTH    = 8,
  parameter  int BYPASS   = 1,
  parameter  int ZERO_REG = 0,
  localparam int AW       = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  wr_op_t           wr_op,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             ovf
);
  logic [DEPTH-1:0][WIDTH-1:0] words;
  logic [DEPTH-1:0]            wrap;
  logic                        wr_en;
  logic [WIDTH-1:0]            cur, byp_val;
  nv_t                         nv;
  logic                        unused_nv;
  logic [1:0][AW-1:0]          ra;
  logic [1:0][WIDTH-1:0]       rdat;
  logic                        ovf_q, ovf_d;

  // Out-of-range and hardwired-zero targets never count as a write.
  always_comb begin
    wr_en = (wr_op != OP_NONE) && (int'(wr_addr) < DEPTH) &&
            !((ZERO_REG != 0) && (wr_addr == '0));
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
      assign words[i] = '0;
      assign wrap[i]  = 1'b0;
    end else begin : g_reg
      reg_word #(.WIDTH(WIDTH)) u_word (
        .clk   (clk),
        .reset (reset),
        .sel   (wr_en && (wr_addr == AW'(i))),
        .op    (wr_op),
        .din   (wr_data),
        .q     (words[i]),
        .wrap  (wrap[i])
      );
    end
  end

  always_comb begin
    cur = '0;
    for (int i = 0; i < DEPTH; i++)
      if (wr_addr == AW'(i)) cur = words[i];
    nv      = next_val(wr_op, MAX_W'(cur), MAX_W'(wr_data), WIDTH);
    byp_val = nv.nxt[WIDTH-1:0];
  end

  assign unused_nv = ^nv;
  assign ra        = {rd_addr_b, rd_addr_a};

  always_comb begin
    rdat = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < DEPTH; i++)
        if (ra[p] == AW'(i)) rdat[p] = words[i];
      if ((BYPASS != 0) && wr_en && !reset && (ra[p] == wr_addr))
        rdat[p] = byp_val;
    end
  end

  assign rd_data_a = rdat[0];
  assign rd_data_b = rdat[1];

  assign ovf_d = |wrap;

  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
endmodule

// File: tb/tb_reg_file.sv
// Drives a bypassing 8-word bank and a non-bypassing 6-word zero-reg bank with the
// same stimulus and compares both against an array-based reference model.
module tb_reg_file;
  import reg_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  wr_op_t      wr_op;
  logic [2:0]  wr_addr, rd_addr_a, rd_addr_b;
  logic [15:0] wr_data;
  logic [15:0] da0, db0, da1, db1;
  logic        ovf0, ovf1;

  int n_chk = 0;
  int n_err = 0;

  int unsigned m [2][8];
  bit          oe [2];
  int          dep [2] = '{8, 6};
  bit          byp [2] = '{1'b1, 1'b0};
  bit          zr  [2] = '{1'b0, 1'b1};

  always #5 clk = ~clk;

  reg_file #(.WIDTH(16), .DEPTH(8), .BYPASS(1), .ZERO_REG(0)) u_dut0 (
    .clk(clk), .reset(reset), .wr_op(wr_op), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(da0), .rd_addr_b(rd_addr_b), .rd_data_b(db0),
    .ovf(ovf0));

  reg_file #(.WIDTH(16), .DEPTH(6), .BYPASS(0), .ZERO_REG(1)) u_dut1 (
    .clk(clk), .reset(reset), .wr_op(wr_op), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(da1), .rd_addr_b(rd_addr_b), .rd_data_b(db1),
    .ovf(ovf1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit eff(int c);
    return (wr_op != OP_NONE) && (int'(wr_addr) < dep[c]) && !(zr[c] && wr_addr == 3'd0);
  endfunction

  function automatic int unsigned nxt(int c);
    case (wr_op)
      OP_LOAD: return int'(wr_data);
      OP_INC:  return (m[c][wr_addr] + 1) % 65536;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned rexp(int c, int a);
    if (a >= dep[c] || (zr[c] && a == 0)) return 0;
    if (byp[c] && !reset && eff(c) && a == int'(wr_addr)) return nxt(c);
    return m[c][a];
  endfunction

  task automatic model_edge();
    for (int c = 0; c < 2; c++) begin
      if (reset) begin
        for (int i = 0; i < 8; i++) m[c][i] = 0;
        oe[c] = 1'b0;
      end else begin
        oe[c] = eff(c) && wr_op == OP_INC && m[c][wr_addr] == 32'hFFFF;
        if (eff(c)) m[c][wr_addr] = nxt(c);
      end
    end
  endtask

  task automatic step(input wr_op_t op, input int wa, input logic [15:0] wd,
                      input int a, input int b, input bit rst);
    wr_op = op; wr_addr = 3'(wa); wr_data = wd;
    rd_addr_a = 3'(a); rd_addr_b = 3'(b); reset = rst;
    @(negedge clk);
    chk("rd_a_byp", {16'd0, da0}, rexp(0, a));
    chk("rd_b_byp", {16'd0, db0}, rexp(0, b));
    chk("rd_a_nb",  {16'd0, da1}, rexp(1, a));
    chk("rd_b_nb",  {16'd0, db1}, rexp(1, b));
    chk("ovf_byp",  {31'd0, ovf0}, {31'd0, oe[0]});
    chk("ovf_nb",   {31'd0, ovf1}, {31'd0, oe[1]});
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    reset = 1'b1; wr_op = OP_NONE; wr_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0;
    @(posedge clk);
    model_edge();
    #1;

    for (int i = 0; i < 8; i++) step(OP_NONE, 0, 16'h0, i, 7 - i, 1'b1);
    step(OP_LOAD, 3, 16'hBEEF, 3, 3, 1'b1);
    step(OP_NONE, 0, 16'h0, 3, 3, 1'b0);

    step(OP_LOAD, 2, 16'h1234, 0, 1, 1'b0);
    step(OP_LOAD, 5, 16'hA5A5, 2, 5, 1'b0);
    step(OP_NONE, 0, 16'h0, 2, 5, 1'b0);
    step(OP_NONE, 0, 16'h0, 4, 6, 1'b0);

    step(OP_LOAD, 1, 16'hFFFE, 1, 1, 1'b0);
    step(OP_INC,  1, 16'h0, 1, 1, 1'b0);
    step(OP_INC,  1, 16'h0, 1, 1, 1'b0);
    step(OP_NONE, 0, 16'h0, 1, 1, 1'b0);
    step(OP_NONE, 0, 16'h0, 1, 1, 1'b0);

    step(OP_LOAD, 4, 16'h0010, 4, 4, 1'b0);
    step(OP_INC,  4, 16'h0, 4, 4, 1'b0);
    step(OP_NONE, 0, 16'h0, 4, 4, 1'b0);

    step(OP_LOAD, 0, 16'hFFFF, 0, 0, 1'b0);
    step(OP_INC,  0, 16'h0, 0, 0, 1'b0);
    step(OP_NONE, 0, 16'h0, 0, 0, 1'b0);
    step(OP_NONE, 0, 16'h0, 0, 0, 1'b0);

    step(OP_LOAD, 7, 16'h5555, 7, 7, 1'b0);
    step(OP_NONE, 0, 16'h0, 7, 6, 1'b0);
    step(OP_LOAD, 2, 16'h1234, 2, 2, 1'b0);
    step(OP_CLR,  2, 16'h0, 2, 2, 1'b0);
    step(OP_NONE, 0, 16'h0, 2, 2, 1'b0);

    for (int n = 0; n < 600; n++) begin
      int          wa, a, b;
      logic [15:0] wd;
      wa = int'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       wd = 16'hFFFF;
        1:       wd = 16'hFFFE;
        default: wd = 16'($urandom);
      endcase
      a = ($urandom_range(0, 2) == 0) ? wa : int'($urandom_range(0, 7));
      b = ($urandom_range(0, 2) == 0) ? wa : int'($urandom_range(0, 7));
      step(wr_op_t'($urandom_range(0, 3)), wa, wd, a, b, $urandom_range(0, 49) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
